// File: rtl/iq_pkg.sv
// Shared constants for the interleaved I-Q datapath: FSM state codes, default
// sample width and the I-first polarity of the iq flag.
package iq_pkg;

    localparam int DW_DEFAULT = 18;

    // Level of the iq flag while the I word is on the bus; consumers key on this.
    localparam logic IQ_I_FIRST = 1'b1;

    typedef logic [1:0] iq_state_t;

    localparam iq_state_t IDLE  = 2'd0;
    localparam iq_state_t S_I   = 2'd1;
    localparam iq_state_t S_Q   = 2'd2;
    localparam iq_state_t S_GAP = 2'd3;

endpackage

// File: rtl/iq_pair_fifo.sv
// Synchronous FIFO holding complex entries {I,Q} side by side so a pair can
// never be split; level disambiguates full from empty.
module iq_pair_fifo
    import iq_pkg::*;
#(
    parameter int W          = 2 * DW_DEFAULT,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [W-1:0]          wr_data,
    input  logic                  pop,
    output logic [W-1:0]          rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [W-1:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic                    do_push;
    logic                    do_pop;

    assign full    = (level == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: storage has no reset; level alone decides which words are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      level <= level + 1'b1;
            else if (do_pop && !do_push) level <= level - 1'b1;
        end
    end

endmodule

// File: rtl/iq_interleaver.sv
// Parallel-to-interleaved I-Q stream source: FIFO-buffered complex samples are
// emitted as an I word then a Q word, with an optional idle gap between pairs.
module iq_interleaver
    import iq_pkg::*;
#(
    parameter int DW         = DW_DEFAULT,
    parameter int DEPTH_LOG2 = 2,
    parameter int GAP_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DW-1:0]         in_i,
    input  logic [DW-1:0]         in_q,
    input  logic [GAP_W-1:0]      gap,
    output logic [DW-1:0]         out_data,
    output logic                  out_iq,
    output logic                  gate_out,
    output logic [DEPTH_LOG2:0]   level
);

    iq_state_t           state;
    iq_state_t           state_nxt;
    logic [GAP_W-1:0]    gap_cnt;
    logic [2*DW-1:0]     head;
    logic                push;
    logic                pop;
    logic                full;
    logic                empty;

    assign in_ready = !full && !rst;
    assign push     = in_valid && in_ready;
    // The head leaves the FIFO as I is replaced by Q; Q is still read from it on that edge.
    assign pop      = (state == S_I);

    iq_pair_fifo #(
        .W          (2 * DW),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data ({in_i, in_q}),
        .pop     (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    // NOTE: the default assignment up front keeps this block free of latches.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!empty) state_nxt = S_I;
            S_I:     state_nxt = S_Q;
            S_Q: begin
                if (gap != '0)   state_nxt = S_GAP;
                else if (!empty) state_nxt = S_I;
                else             state_nxt = IDLE;
            end
            S_GAP:   if (gap_cnt == '0) state_nxt = empty ? IDLE : S_I;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gap_cnt  <= '0;
            out_data <= '0;
            out_iq   <= 1'b0;
            gate_out <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state == S_Q && gap != '0)
                gap_cnt <= gap - 1'b1;
            else if (state == S_GAP && gap_cnt != '0)
                gap_cnt <= gap_cnt - 1'b1;

            // Output registers follow the state being entered so they name what is on the bus.
            case (state_nxt)
                S_I: begin
                    out_data <= head[2*DW-1:DW];
                    out_iq   <= IQ_I_FIRST;
                    gate_out <= 1'b1;
                end
                S_Q: begin
                    out_data <= head[DW-1:0];
                    out_iq   <= !IQ_I_FIRST;
                    gate_out <= 1'b1;
                end
                default: begin
                    out_data <= '0;
                    out_iq   <= 1'b0;
                    gate_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iq_interleaver.sv
// Self-checking bench for iq_interleaver: directed scenarios plus a randomized
// run, all compared against a timeline model of the interleaved stream.
module tb_iq_interleaver;

    localparam int DW    = 18;
    localparam int DL    = 2;
    localparam int GW    = 4;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_i = '0;
    logic [DW-1:0] in_q = '0;
    logic [GW-1:0] gap = '0;
    logic [DW-1:0] out_data;
    logic          out_iq;
    logic          gate_out;
    logic [DL:0]   level;

    always #5 clk = ~clk;

    iq_interleaver #(.DW(DW), .DEPTH_LOG2(DL), .GAP_W(GW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_i     (in_i),
        .in_q     (in_q),
        .gap      (gap),
        .out_data (out_data),
        .out_iq   (out_iq),
        .gate_out (gate_out),
        .level    (level)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Model: queued entries, the entry whose I is out (held until its Q is out),
    // and a countdown of idle cycles still owed after a Q word.
    logic [2*DW-1:0] fifo_q[$];
    logic [2*DW-1:0] held;
    bit              holding;
    bit              q_next;
    bit              after_q;
    int              rem;
    logic [DW-1:0]   exp_data;
    bit              exp_iq;
    bit              exp_gate;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int mlevel();
        return fifo_q.size() + (holding ? 1 : 0);
    endfunction

    task automatic model_reset();
        fifo_q.delete();
        holding  = 0;
        q_next   = 0;
        after_q  = 0;
        rem      = 0;
        exp_data = '0;
        exp_iq   = 0;
        exp_gate = 0;
    endtask

    task automatic model_edge();
        bit pushed;
        pushed   = in_valid && (mlevel() < DEPTH);
        exp_data = '0;
        exp_iq   = 0;
        exp_gate = 0;
        if (q_next) begin
            exp_data = held[DW-1:0];
            exp_gate = 1;
            holding  = 0;
            q_next   = 0;
            after_q  = 1;
        end else if (after_q && gap != '0) begin
            after_q = 0;
            rem     = int'(gap) - 1;
        end else if (rem > 0) begin
            rem--;
        end else begin
            after_q = 0;
            if (fifo_q.size() > 0) begin
                held     = fifo_q.pop_front();
                holding  = 1;
                q_next   = 1;
                exp_data = held[2*DW-1:DW];
                exp_iq   = 1;
                exp_gate = 1;
            end
        end
        if (pushed) fifo_q.push_back({in_i, in_q});
    endtask

    task automatic compare();
        check("out_data", 32'(out_data), 32'(exp_data));
        check("out_iq",   32'(out_iq),   32'(exp_iq));
        check("gate_out", 32'(gate_out), 32'(exp_gate));
        check("level",    32'(level),    32'(mlevel()));
        check("in_ready", 32'(in_ready), 32'(mlevel() < DEPTH));
    endtask

    task automatic step(input bit v, input logic [DW-1:0] i, input logic [DW-1:0] q);
        in_valid = v;
        in_i     = i;
        in_q     = q;
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic idle_steps(input int n);
        for (int k = 0; k < n; k++) step(0, '0, '0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [12:0] pat;
        int          nxt;
        int          pushes;
        int          obs_q;
        bit          acc;
        logic [DW-1:0] ri;
        logic [DW-1:0] rq;

        model_reset();
        #3;
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_gate",     32'(gate_out), 32'h0);
        check("rst_level",    32'(level),    32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check("ready_after_rst", 32'(in_ready), 32'h1);

        // Single sample with extreme signed values.
        step(1, 18'h1FFFF, 18'h20000);
        step(0, '0, '0);
        check("single_i_data", 32'(out_data), 32'h1FFFF);
        check("single_i_iq",   32'(out_iq),   32'h1);
        check("single_i_gate", 32'(gate_out), 32'h1);
        step(0, '0, '0);
        check("single_q_data", 32'(out_data), 32'h20000);
        check("single_q_iq",   32'(out_iq),   32'h0);
        step(0, '0, '0);
        check("single_end_gate",  32'(gate_out), 32'h0);
        check("single_end_level", 32'(level),    32'h0);
        idle_steps(2);

        // Back-pressure: valid held high with samples 1..8, gap 0.
        gap = '0;
        nxt = 1;
        for (int e = 0; e < 20; e++) begin
            acc = (mlevel() < DEPTH);
            step(nxt <= 8, DW'(nxt), DW'(-nxt));
            if (acc && nxt <= 8) nxt++;
            if (e == 5) begin
                check("bp_level_full", 32'(level),    32'd4);
                check("bp_ready_low",  32'(in_ready), 32'h0);
            end
            if (e >= 1 && e <= 16) check("bp_gate_high", 32'(gate_out), 32'h1);
        end
        idle_steps(2);

        // Gap of 3 with three samples preloaded back to back.
        gap = 4'd3;
        pat = 13'b1100011000110;
        for (int e = 0; e < 16; e++) begin
            step(e < 3, DW'(32'h100 + e), DW'(32'h200 + e));
            if (e >= 1 && e <= 13) check("gap_pattern", 32'(gate_out), 32'(pat[13 - e]));
        end
        idle_steps(2);

        // Simultaneous push and pop leaves level unchanged.
        gap = '0;
        step(1, 18'h00A, 18'h00B);
        step(1, 18'h00C, 18'h00D);
        check("pp_level_before", 32'(level), 32'd2);
        step(1, 18'h00E, 18'h00F);
        check("pp_level_same", 32'(level), 32'd2);
        idle_steps(8);

        // Asynchronous reset while I is on the outputs.
        step(1, 18'h15555, 18'h0AAAA);
        step(0, '0, '0);
        check("mid_in_s_i", 32'(out_iq), 32'h1);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_gate",  32'(gate_out), 32'h0);
        check("mid_rst_data",  32'(out_data), 32'h0);
        check("mid_rst_level", 32'(level),    32'h0);
        check("mid_rst_ready", 32'(in_ready), 32'h0);
        model_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        idle_steps(3);
        step(1, 18'h01234, 18'h3FEDC);
        step(0, '0, '0);
        check("post_rst_i", 32'(out_data), 32'h01234);
        step(0, '0, '0);
        check("post_rst_q", 32'(out_data), 32'h3FEDC);
        idle_steps(2);

        // Random valid and gap; the stream must match input order.
        pushes = 0;
        obs_q  = 0;
        for (int e = 0; e < 400; e++) begin
            if (e % 7 == 0) gap = GW'($urandom_range(0, 2));
            acc = (mlevel() < DEPTH);
            ri  = DW'($urandom());
            rq  = DW'($urandom());
            step((pushes < 20) && ($urandom_range(0, 1) == 1), ri, rq);
            if (acc && in_valid) pushes++;
            if (gate_out === 1'b1 && out_iq === 1'b0) obs_q++;
            if (pushes == 20 && mlevel() == 0 && !after_q && rem == 0 && gate_out === 1'b0) break;
        end
        check("rand_all_pairs_out", 32'(obs_q), 32'd20);
        check("rand_drained_level", 32'(level), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/iq_interleaver.md
# iq_interleaver

Stream source for the interleaved I-Q datapath. The block accepts parallel complex samples (I and Q side by side) through a valid/ready handshake and buffers them in a small FIFO. It emits each sample as a time-interleaved pair, I then Q, with the `iq` flag and `gate` marker. This is the convention consumed by the flow-through vector multiplier and the rest of the I-Q pipeline. An optional programmable gap between pairs lets the stream pace downstream blocks that cannot take back-to-back pairs.

## Interface
- `DW`, 18: sample width, signed, per component.
- `DEPTH_LOG2`, 2: FIFO depth is 2**DEPTH_LOG2 complex entries (default 4).
- `GAP_W`, 4: width of the inter-pair gap setting.
- `clk`  in  1  rising-edge clock; all logic is synchronous to it.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  parallel sample offered.
- `in_ready`  out  1  FIFO can accept; equals `!full`, and is 0 while `rst` is high.
- `in_i`  in  DW  real part, signed.
- `in_q`  in  DW  imaginary part, signed.
- `gap`  in  GAP_W  idle cycles inserted after each Q word; treated as quasi-static.
- `out_data`  out  DW  interleaved output word, signed.
- `out_iq`  out  1  high while `out_data` is I, low otherwise.
- `gate_out`  out  1  high while `out_data` is valid (I or Q).
- `level`  out  DEPTH_LOG2+1  current FIFO occupancy.

## Operation
- **Push:** a push occurs on an edge where `in_valid && in_ready`. `{in_i,in_q}` is written to the FIFO tail.
- **Full:** when the FIFO is full, `in_ready` is 0 even if a pop happens on the same edge. No push-through when full.
- **FSM states:** the state register names what is on the outputs.
  - IDLE: outputs show no valid word.
  - S_I: I word of the head entry on the outputs.
  - S_Q: Q word of the head entry on the outputs.
  - S_GAP: inter-pair idle cycles.
- **Transitions:**
  - IDLE → S_I when `level != 0`.
  - S_I → S_Q always. The head entry is popped on this edge.
  - S_Q → S_GAP with counter = gap-1 when `gap != 0`.
  - S_Q → S_I when `gap == 0` and `level != 0`.
  - S_Q → IDLE otherwise.
  - S_GAP: the counter decrements. At 0 the state goes to S_I if `level != 0`, else IDLE.
- **Output registers** are loaded on the same edge as the state:
  - S_I: `out_data=I`, `out_iq=1`, `gate_out=1`.
  - S_Q: `out_data=Q`, `out_iq=0`, `gate_out=1`.
  - IDLE and S_GAP: `out_data=0`, `out_iq=0`, `gate_out=0`.
- **Data integrity:** data pass unmodified. There is no arithmetic, saturation or sign change, and I and Q of an entry are never split across entries.
- **Pair atomicity:** once I is emitted, Q follows on the very next cycle.
- **`level` update:** +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- **Pointers** wrap modulo 2**DEPTH_LOG2. `level` distinguishes full from empty.
- **Reset:** asserting `rst` at any time immediately clears state to IDLE, pointers, `level` and all outputs to 0.
  - A pair whose I was already emitted has its Q discarded.
  - FIFO contents are lost.

## Timing
- **Reset values:** `out_data=0`, `out_iq=0`, `gate_out=0`, `level=0`, `in_ready=0` while in reset and 1 from the first cycle after deassertion.
- **Latency:** for an entry pushed at edge k into an empty FIFO with the FSM in IDLE:
  - I is on the outputs after edge k+1.
  - Q is on the outputs after edge k+2.
- **Throughput:**
  - With `gap=0`, one pair per 2 cycles, with no idle cycle between pairs while the FIFO is non-empty.
  - With gap=G, one pair per 2+G cycles.
- **`gap` changes** take effect at the next S_Q exit.

## Structure
- **Shared package (`iq_pkg`):**
  - state enumeration (IDLE, S_I, S_Q, S_GAP);
  - default `DW=18`;
  - the I-first pairing constant, so consumers agree on the `iq` polarity.
- **Sub-module `iq_pair_fifo`:**
  - synchronous 2·DW-wide FIFO with push/pop/full/empty/level;
  - asynchronous reset of pointers and level;
  - memory not reset.
- **Top level:** FSM, gap counter and output registers.

## Test plan
- **Single sample:** reset, push (I=0x1FFFF, Q=0x20000) at edge 0 → after edge 1 `out_data=0x1FFFF, out_iq=1, gate_out=1`; after edge 2 `out_data=0x20000, out_iq=0`; after edge 3 `gate_out=0`, `level=0`.
- **Back-pressure:** `gap=0`, `in_valid` held high with distinct samples 1..8 → `level` reaches 4 after edge 5; `in_ready=0` for the cycle before edge 6; output sequence is I1,Q1,I2,Q2,... with `gate_out` continuously high and no sample lost or duplicated.
- **Gap:** `gap=3`, three samples preloaded → pattern I,Q,idle,idle,idle,I,Q,idle,idle,idle,I,Q, then IDLE.
- **Simultaneous push/pop:** with `level=2` and a push on the edge entering S_Q → `level` stays 2.
- **Reset mid-pair:** assert `rst` asynchronously during S_I → `gate_out`, `out_data`, `level` go to 0 before the next edge; no Q is emitted after release; the next push yields a clean I-then-Q pair with 2-edge latency.
- **Wrap-around:** 20 random samples with random `in_valid` and `gap` in 0..2 → the output stream equals the input order exactly, checked against a scoreboard.
